exu_mdu: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit beside the single-cycle EXU ALU.

---
 rtl/exu_mdu.sv | 138 +++++++++++++
 tb/tb_exu_mdu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/exu_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2^MUL_BITS shift-add multiply,
// radix-2 restoring divide, valid/ready on both sides.
//
// state | meaning
// IDLE  | ready to accept an operation
// MUL   | multiplier digits being retired, then sign fix-up
// DIV   | quotient bits being developed, then sign fix-up
// DONE  | result presented, waiting for out_ready
module exu_mdu #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   MUL_ITERS = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0]   DIV_ITERS = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        func_q;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  logic              sgn1_op, sgn2_op, s1, s2, div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag1, mag2, spec_res;
  logic [MUL_BITS-1:0]    digit;
  logic [XLEN+MUL_BITS-1:0] mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  assign sgn1_op  = (func == 3'b001) || (func == 3'b010) || (func == 3'b100) || (func == 3'b110);
  assign sgn2_op  = (func == 3'b001) || (func == 3'b100) || (func == 3'b110);
  assign s1       = sgn1_op && src1[XLEN-1];
  assign s2       = sgn2_op && src2[XLEN-1];
  assign mag1     = s1 ? -src1 : src1;
  assign mag2     = s2 ? -src2 : src2;
  assign div_zero = (src2 == '0);
  assign div_ovf  = sgn2_op && func[2] && (src1 == MIN_NEG) && (src2 == '1);
  assign special  = func[2] && (div_zero || div_ovf);
  assign spec_res = func[1] ? (div_zero ? src1 : '0) : (div_zero ? '1 : src1);

  // acc holds {partial product high, remaining multiplier} for MUL and
  // {partial remainder, dividend/quotient} for DIV.
  assign digit    = acc[MUL_BITS-1:0];
  assign mul_sum  = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]}
                  + ({{MUL_BITS{1'b0}}, opnd} * {{XLEN{1'b0}}, digit});
  assign mul_next = {mul_sum, acc[XLEN-1:MUL_BITS]};

  assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  assign div_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      func_q    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          func_q <= func[1:0];
          if (special) begin
            // Parked in DIV with a zero count so the answer lands one edge later
            // through the ordinary quotient/remainder fix-up path.
            acc   <= {spec_res, spec_res};
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
            state <= DIV;
          end else begin
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            opnd  <= func[2] ? mag2 : mag1;
            acc   <= {{XLEN{1'b0}}, func[2] ? mag1 : mag2};
            cnt   <= func[2] ? DIV_ITERS : MUL_ITERS;
            state <= func[2] ? DIV : MUL;
          end
        end
        MUL: if (cnt != '0) begin
          acc <= mul_next;
          cnt <= cnt - CW'(1);
        end else begin
          result    <= (func_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DIV: if (cnt != '0) begin
          acc <= div_next;
          cnt <= cnt - CW'(1);
        end else begin
          result    <= func_q[1] ? rem_fix : quo_fix;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_mdu.sv
// Directed bench for exu_mdu: an arithmetic reference model with a cycle-level
// latency model, checked every cycle, plus hand-computed literal results.
module tb_exu_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  func = 3'b000;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  exu_mdu #(.XLEN(32), .MUL_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 9;
    if (b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Cycle model: phase 0 idle, 1 computing, 2 result held.
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [31:0] m_pend  = '0;
  logic [31:0] m_res   = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
      chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
      chk("result", result, m_res);
    end
    if (rst) begin
      m_phase = 0;
      m_res   = '0;
    end else if (flush) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_pend  = model(func, src1, src2);
        m_cnt   = latency(func, src1, src2);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_phase = 2;
        m_res   = m_pend;
      end
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("accept_wait", {31'b0, in_ready}, 32'd1);
    func = f; src1 = a; src2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    src1 = $urandom; src2 = $urandom;
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp, input int lat);
    int n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_lat"}, 32'(n), 32'(lat));
    chk(name, result, exp);
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(f, a, b);
    wait_result(name, exp, lat);
    chk({name, "_model"}, model(f, a, b), exp);
    tick();
  endtask

  initial begin
    logic [31:0] held;
    int seen;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_result", result, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    run("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 9);
    run("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 9);
    run("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 9);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 9);
    run("mulh2",  3'd1, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 9);
    run("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run("remu",   3'd7, 32'd100,        32'd7,         32'd2,         33);
    run("div2",   3'd4, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    run("divu0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run("remu0",  3'd7, 32'd5,          32'd0,         32'd5,         1);
    run("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // Backpressure in DONE
    out_ready = 1'b0;
    issue(3'd0, 32'd6, 32'd7);
    wait_result("bp", 32'd42, 9);
    held = result;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_hold", {31'b0, out_valid}, 32'd1);
      chk("bp_result_hold", result, held);
      chk("bp_not_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after", {31'b0, in_ready}, 32'd1);
    chk("bp_valid_after", {31'b0, out_valid}, 32'd0);
    run("bp_next", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    // Flush and reset mid-divide
    for (int k = 0; k < 2; k++) begin
      issue(3'd4, 32'hFFFF_FFF9, 32'd2);
      for (int i = 0; i < 9; i++) tick();
      if (k == 0) flush = 1'b1; else rst = 1'b1;
      tick();
      flush = 1'b0; rst = 1'b0;
      chk("abort_ready", {31'b0, in_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      run("post_abort_mul", 3'd0, 32'd3, 32'd4, 32'd12, 9);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
